// File: rtl/tx_framer_pkg.sv
// ---------------------------------------------------------------------------
// tx_framer_pkg -- shared types and constants for the GMII TX framer and the
// CRC-32 helper (also used by the RX CRC checker).
// Build option: TX_PAD_EN adds the PAD state (short-frame padding).
// ---------------------------------------------------------------------------
package tx_framer_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam int unsigned PREAMBLE_LEN  = 7;
    localparam int unsigned FCS_LEN       = 4;
    localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY      = 32'hEDB8_8320;
    localparam int unsigned BYTE_CNT_W    = 11;

    // Encodings are fixed so both builds agree on state values.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PREAMBLE = 3'd1,
        SFD      = 3'd2,
        DATA     = 3'd3,
`ifdef TX_PAD_EN
        PAD      = 3'd4,
`endif
        FCS      = 3'd5,
        ABORT    = 3'd6,
        IPG      = 3'd7
    } tx_state_t;

    // One GMII transmit beat: TXD, TX_EN, TX_ER.
    typedef struct packed {
        logic [7:0] data;
        logic       valid;
        logic       error;
    } gmii_beat_t;

    function automatic gmii_beat_t mk_beat(input logic [7:0] d, input logic er);
        gmii_beat_t b;
        b.data  = d;
        b.valid = 1'b1;
        b.error = er;
        return b;
    endfunction

endpackage

// File: rtl/gmii_if.sv
// ---------------------------------------------------------------------------
// gmii_if -- GMII transmit bundle: data[7:0], valid (TX_EN), error (TX_ER).
// master drives, slave observes.
// ---------------------------------------------------------------------------
interface gmii_if;
    logic [7:0] data;
    logic       valid;
    logic       error;

    modport master (output data, output valid, output error);
    modport slave  (input  data, input  valid, input  error);
endinterface

// File: rtl/crc32_byte.sv
// ---------------------------------------------------------------------------
// crc32_byte -- combinational one-byte step of the reflected Ethernet CRC-32.
// Ports:
//   crc_i  [31:0]  current CRC register
//   data_i [7:0]   byte to fold in (bit 0 first)
//   crc_o  [31:0]  next CRC register (not complemented)
// ---------------------------------------------------------------------------
module crc32_byte
    import tx_framer_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    // Bit-serial LFSR unrolled over the eight data bits, LSB first.
    always_comb begin
        crc_o = crc_i;
        for (int i = 0; i < 8; i++) begin
            crc_o = (crc_o >> 1) ^ ((crc_o[0] ^ data_i[i]) ? CRC_POLY : 32'h0);
        end
    end

endmodule

// File: rtl/gmii_tx_framer.sv
// ---------------------------------------------------------------------------
// gmii_tx_framer -- turns an upstream byte stream (DA onward, no FCS) into a
// GMII frame: preamble, SFD, data, optional pad, CRC-32 FCS, inter-packet gap.
// Upstream underflow mid-frame emits one TX_ER cycle and drains the frame.
// Build option: TX_PAD_EN pads short frames to MIN_DATA_BYTES.
// Ports:
//   clk, rst           clock, async active-high reset
//   s_data_i/valid/last upstream byte stream
//   s_ready_o          byte accepted this cycle when s_valid_i is high
//   gmii_tx_if_o       registered GMII TXD/TX_EN/TX_ER
//   error_pulse_o      one-cycle pulse per aborted frame
// ---------------------------------------------------------------------------
module gmii_tx_framer
    import tx_framer_pkg::*;
#(
    parameter int unsigned IPG_BYTES      = 12,
    parameter int unsigned MIN_DATA_BYTES = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_data_i,
    input  logic       s_valid_i,
    input  logic       s_last_i,
    output logic       s_ready_o,
    gmii_if.master     gmii_tx_if_o,
    output logic       error_pulse_o
);

    localparam int unsigned IPG_CNT_W = (IPG_BYTES > 2) ? $clog2(IPG_BYTES) : 1;

    tx_state_t              state_q;
    gmii_beat_t             tx_q;
    logic                   ready_q;
    logic                   err_pulse_q;
    logic [31:0]            crc_q;
    logic [31:0]            crc_d;
    logic [BYTE_CNT_W-1:0]  byte_cnt_q;
    logic [BYTE_CNT_W-1:0]  byte_cnt_d;
    logic [2:0]             ph_cnt_q;
    logic [IPG_CNT_W-1:0]   ipg_cnt_q;
    logic [7:0]             crc_byte_c;
    logic [7:0]             fcs_byte_c;

    // Pad bytes are zeros folded into the CRC; otherwise the CRC sees upstream data.
`ifdef TX_PAD_EN
    assign crc_byte_c = (state_q == PAD) ? 8'h00 : s_data_i;
`else
    assign crc_byte_c = s_data_i;
    // Without padding the minimum length is not consumed.
    logic unused_cfg;
    assign unused_cfg = ^32'(MIN_DATA_BYTES);
`endif

    crc32_byte u_crc (
        .crc_i  (crc_q),
        .data_i (crc_byte_c),
        .crc_o  (crc_d)
    );

    // Saturating byte count: stays at 2047 for oversize frames.
    assign byte_cnt_d = (byte_cnt_q == {BYTE_CNT_W{1'b1}}) ? byte_cnt_q
                                                          : byte_cnt_q + BYTE_CNT_W'(1);

    // FCS goes out complemented, least-significant byte first.
    assign fcs_byte_c = 8'(~crc_q >> {ph_cnt_q[1:0], 3'b000});

    // Framer FSM; every output is loaded here so GMII lags the state by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            tx_q        <= '0;
            ready_q     <= 1'b0;
            err_pulse_q <= 1'b0;
            crc_q       <= CRC_INIT;
            byte_cnt_q  <= '0;
            ph_cnt_q    <= '0;
            ipg_cnt_q   <= '0;
        end else begin
            tx_q        <= '0;
            err_pulse_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (s_valid_i) begin
                        state_q  <= PREAMBLE;
                        ph_cnt_q <= '0;
                    end
                end
                PREAMBLE: begin
                    tx_q       <= mk_beat(PREAMBLE_BYTE, 1'b0);
                    crc_q      <= CRC_INIT;
                    byte_cnt_q <= '0;
                    if (ph_cnt_q == 3'(PREAMBLE_LEN - 1)) begin
                        state_q <= SFD;
                    end else begin
                        ph_cnt_q <= ph_cnt_q + 3'd1;
                    end
                end
                SFD: begin
                    tx_q    <= mk_beat(SFD_BYTE, 1'b0);
                    state_q <= DATA;
                    ready_q <= 1'b1;
                end
                DATA: begin
                    if (s_valid_i) begin
                        tx_q       <= mk_beat(s_data_i, 1'b0);
                        crc_q      <= crc_d;
                        byte_cnt_q <= byte_cnt_d;
                        if (s_last_i) begin
                            ready_q  <= 1'b0;
                            ph_cnt_q <= '0;
`ifdef TX_PAD_EN
                            state_q  <= (32'(byte_cnt_d) < MIN_DATA_BYTES) ? PAD : FCS;
`else
                            state_q  <= FCS;
`endif
                        end
                    end else begin
                        // Underflow: single TX_ER beat, then swallow the rest of the frame.
                        tx_q        <= mk_beat(8'h00, 1'b1);
                        err_pulse_q <= 1'b1;
                        state_q     <= ABORT;
                    end
                end
`ifdef TX_PAD_EN
                PAD: begin
                    tx_q       <= mk_beat(8'h00, 1'b0);
                    crc_q      <= crc_d;
                    byte_cnt_q <= byte_cnt_d;
                    if (32'(byte_cnt_d) >= MIN_DATA_BYTES) begin
                        state_q  <= FCS;
                        ph_cnt_q <= '0;
                    end
                end
`endif
                FCS: begin
                    tx_q <= mk_beat(fcs_byte_c, 1'b0);
                    if (ph_cnt_q == 3'(FCS_LEN - 1)) begin
                        state_q   <= IPG;
                        ipg_cnt_q <= '0;
                    end else begin
                        ph_cnt_q <= ph_cnt_q + 3'd1;
                    end
                end
                ABORT: begin
                    if (s_valid_i && s_last_i) begin
                        state_q   <= IPG;
                        ready_q   <= 1'b0;
                        ipg_cnt_q <= '0;
                    end
                end
                IPG: begin
                    // A waiting frame starts its preamble straight out of the gap.
                    if (32'(ipg_cnt_q) == IPG_BYTES - 1) begin
                        state_q  <= s_valid_i ? PREAMBLE : IDLE;
                        ph_cnt_q <= '0;
                    end else begin
                        ipg_cnt_q <= ipg_cnt_q + IPG_CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign gmii_tx_if_o.data  = tx_q.data;
    assign gmii_tx_if_o.valid = tx_q.valid;
    assign gmii_tx_if_o.error = tx_q.error;
    assign s_ready_o          = ready_q;
    assign error_pulse_o      = err_pulse_q;

endmodule

// File: tb/tb_gmii_tx_framer.sv
// ---------------------------------------------------------------------------
// tb_gmii_tx_framer -- directed self-checking bench for gmii_tx_framer.
// Build option: TX_PAD_EN (must match the RTL build).
// ---------------------------------------------------------------------------
module tb_gmii_tx_framer;

    localparam int MIN = 60;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] s_data_i;
    logic       s_valid_i;
    logic       s_last_i;
    logic       s_ready_o;
    logic       error_pulse_o;

    gmii_if gmii ();

    gmii_tx_framer #(.IPG_BYTES(12), .MIN_DATA_BYTES(MIN)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_data_i      (s_data_i),
        .s_valid_i     (s_valid_i),
        .s_last_i      (s_last_i),
        .s_ready_o     (s_ready_o),
        .gmii_tx_if_o  (gmii),
        .error_pulse_o (error_pulse_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    logic [7:0] txb [0:255];
    logic [7:0] mon_data [$];
    logic       mon_err  [$];
    int         mon_cyc  [$];
    int         pulse_cnt = 0;
    int         pulse_cyc = -1;

    // Capture every TX_EN beat and every error pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (gmii.valid) begin
                mon_data.push_back(gmii.data);
                mon_err.push_back(gmii.error);
                mon_cyc.push_back(cyc);
            end
            if (error_pulse_o) begin
                pulse_cnt = pulse_cnt + 1;
                pulse_cyc = cyc;
            end
        end
    end

    task automatic clear_mon();
        mon_data.delete();
        mon_err.delete();
        mon_cyc.delete();
        pulse_cnt = 0;
        pulse_cyc = -1;
    endtask

    // Reference CRC step: XOR the byte in, then shift eight times.
    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction

    function automatic logic [31:0] mon_crc(input int first, input int n);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int k = 0; k < n; k++)
            if (first + k < mon_data.size()) c = crc_step(c, mon_data[first + k]);
        return ~c;
    endfunction

    // FCS bytes ending just before index e, reassembled LSB first.
    function automatic logic [31:0] mon_fcs(input int e);
        logic [31:0] f;
        f = 32'h0;
        for (int k = 0; k < 4; k++)
            if (e - 4 + k >= 0 && e - 4 + k < mon_data.size())
                f[8*k +: 8] = mon_data[e - 4 + k];
        return f;
    endfunction

    function automatic int hdr_bad(input int base);
        int bad;
        logic [7:0] exp_b;
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            exp_b = (k < 7) ? 8'h55 : 8'hD5;
            if (base + k >= mon_data.size()) bad++;
            else if (mon_data[base + k] !== exp_b) bad++;
        end
        return bad;
    endfunction

    function automatic int data_bad(input int base, input int sent, input int total);
        int bad;
        logic [7:0] exp_b;
        bad = 0;
        for (int k = 0; k < total; k++) begin
            exp_b = (k < sent) ? txb[k] : 8'h00;
            if (base + 8 + k >= mon_data.size()) bad++;
            else if (mon_data[base + 8 + k] !== exp_b) bad++;
        end
        return bad;
    endfunction

    function automatic int err_count();
        int n;
        n = 0;
        foreach (mon_err[k]) if (mon_err[k]) n++;
        return n;
    endfunction

    function automatic int exp_total(input int sent);
`ifdef TX_PAD_EN
        return (sent < MIN) ? MIN : sent;
`else
        return sent;
`endif
    endfunction

    // Drive a frame from txb; optional one-cycle valid gap at byte gap_at,
    // optional early stop after stop_at accepted bytes.
    task automatic send_frame(input int len, input int gap_at, input int stop_at, input bit release_v);
        int i;
        int guard;
        bit gap_done;
        i = 0;
        guard = 0;
        gap_done = 1'b0;
        while (i < len && i < stop_at) begin
            @(negedge clk);
            guard++;
            if (guard > 4000) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: accepted %0d of %0d bytes", i, len);
                break;
            end
            if (i == gap_at && !gap_done && s_ready_o) begin
                s_valid_i = 1'b0;
                s_last_i  = 1'b0;
                gap_done  = 1'b1;
            end else begin
                s_valid_i = 1'b1;
                s_data_i  = txb[i];
                s_last_i  = (i == len - 1);
                if (s_ready_o) i++;
            end
        end
        if (release_v) begin
            @(negedge clk);
            s_valid_i = 1'b0;
            s_last_i  = 1'b0;
        end
    endtask

    task automatic wait_quiet();
        int q;
        int g;
        q = 0;
        g = 0;
        while (q < 30) begin
            @(negedge clk);
            g++;
            if (gmii.valid) q = 0; else q++;
            if (g > 3000) begin
                checks++;
                errors++;
                $display("FAIL quiet_timeout: TX_EN still active after %0d cycles", g);
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s_valid_i = 1'b1;
        s_last_i = 1'b0;
        s_data_i = 8'h00;
        repeat (4) @(negedge clk);
        checks++; if (gmii.data !== 8'h00) begin errors++; $display("FAIL rst_data: got %h want 00", gmii.data); end
        checks++; if (gmii.valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", gmii.valid); end
        checks++; if (gmii.error !== 1'b0) begin errors++; $display("FAIL rst_error: got %b want 0", gmii.error); end
        checks++; if (s_ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", s_ready_o); end
        checks++; if (error_pulse_o !== 1'b0) begin errors++; $display("FAIL rst_pulse: got %b want 0", error_pulse_o); end
        s_valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (gmii.valid !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b want 0", gmii.valid); end
        clear_mon();
    endtask

    task automatic test_crc_vector();
        int tot;
        logic [31:0] exp_fcs;
        for (int k = 0; k < 9; k++) txb[k] = 8'(8'h31 + k);
        tot = exp_total(9);
        send_frame(9, -1, 9, 1'b1);
        wait_quiet();
`ifdef TX_PAD_EN
        exp_fcs = mon_crc(8, tot);
`else
        exp_fcs = 32'hCBF4_3926;
`endif
        checks++; if (mon_data.size() != 8 + tot + 4) begin errors++; $display("FAIL vec_len: got %0d want %0d", mon_data.size(), 8 + tot + 4); end
        checks++; if (hdr_bad(0) != 0) begin errors++; $display("FAIL vec_preamble: %0d bad bytes want 0", hdr_bad(0)); end
        checks++; if (data_bad(0, 9, tot) != 0) begin errors++; $display("FAIL vec_data: %0d bad bytes want 0", data_bad(0, 9, tot)); end
        checks++; if (mon_fcs(8 + tot + 4) !== exp_fcs) begin errors++; $display("FAIL vec_fcs: got %h want %h", mon_fcs(8 + tot + 4), exp_fcs); end
        checks++; if (err_count() != 0 || pulse_cnt != 0) begin errors++; $display("FAIL vec_err: got %0d/%0d want 0/0", err_count(), pulse_cnt); end
        clear_mon();
    endtask

    task automatic test_short_frame();
        int tot;
        int exp_len;
        txb[0] = 8'hAB;
        tot = exp_total(1);
`ifdef TX_PAD_EN
        exp_len = 72;
`else
        exp_len = 13;
`endif
        send_frame(1, -1, 1, 1'b1);
        wait_quiet();
        checks++; if (mon_data.size() != exp_len) begin errors++; $display("FAIL short_len: got %0d want %0d", mon_data.size(), exp_len); end
        checks++; if (data_bad(0, 1, tot) != 0) begin errors++; $display("FAIL short_data: %0d bad bytes want 0", data_bad(0, 1, tot)); end
        checks++; if (mon_fcs(8 + tot + 4) !== mon_crc(8, tot)) begin errors++; $display("FAIL short_fcs: got %h want %h", mon_fcs(8 + tot + 4), mon_crc(8, tot)); end
        clear_mon();
    endtask

    task automatic test_underflow();
        int n;
        for (int k = 0; k < 100; k++) txb[k] = 8'(k + 1);
        send_frame(100, 10, 100, 1'b1);
        wait_quiet();
        n = mon_data.size();
        checks++; if (n != 19) begin errors++; $display("FAIL uf_len: got %0d want 19", n); end
        checks++; if (err_count() != 1) begin errors++; $display("FAIL uf_errcnt: got %0d want 1", err_count()); end
        checks++; if (pulse_cnt != 1) begin errors++; $display("FAIL uf_pulses: got %0d want 1", pulse_cnt); end
        checks++; if (data_bad(0, 10, 10) != 0) begin errors++; $display("FAIL uf_data: %0d bad bytes want 0", data_bad(0, 10, 10)); end
        if (n > 0) begin
            checks++; if (mon_err[n-1] !== 1'b1 || mon_data[n-1] !== 8'h00) begin errors++; $display("FAIL uf_beat: got er=%b d=%h want er=1 d=00", mon_err[n-1], mon_data[n-1]); end
            checks++; if (pulse_cyc != mon_cyc[n-1]) begin errors++; $display("FAIL uf_pulse_align: got cycle %0d want %0d", pulse_cyc, mon_cyc[n-1]); end
        end
        checks++; if (s_ready_o !== 1'b0) begin errors++; $display("FAIL uf_ready_after: got %b want 0", s_ready_o); end
        clear_mon();
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 64; k++) txb[k] = 8'(k * 7 + 3);
        send_frame(64, -1, 64, 1'b0);
        send_frame(64, -1, 64, 1'b1);
        wait_quiet();
        checks++; if (mon_data.size() != 152) begin errors++; $display("FAIL b2b_len: got %0d want 152", mon_data.size()); end
        if (mon_data.size() == 152) begin
            checks++; if (mon_cyc[76] - mon_cyc[75] - 1 != 12) begin errors++; $display("FAIL b2b_gap: got %0d want 12", mon_cyc[76] - mon_cyc[75] - 1); end
            checks++; if (mon_cyc[75] - mon_cyc[0] != 75) begin errors++; $display("FAIL b2b_contig: got %0d want 75", mon_cyc[75] - mon_cyc[0]); end
        end
        checks++; if (hdr_bad(76) != 0) begin errors++; $display("FAIL b2b_preamble2: %0d bad bytes want 0", hdr_bad(76)); end
        checks++; if (mon_fcs(76) !== mon_crc(8, 64)) begin errors++; $display("FAIL b2b_fcs1: got %h want %h", mon_fcs(76), mon_crc(8, 64)); end
        checks++; if (mon_fcs(152) !== mon_crc(84, 64)) begin errors++; $display("FAIL b2b_fcs2: got %h want %h", mon_fcs(152), mon_crc(84, 64)); end
        checks++; if (data_bad(76, 64, 64) != 0) begin errors++; $display("FAIL b2b_data2: %0d bad bytes want 0", data_bad(76, 64, 64)); end
        clear_mon();
    endtask

    task automatic test_reset_mid();
        int tot;
        for (int k = 0; k < 30; k++) txb[k] = 8'(k ^ 8'h5A);
        send_frame(30, -1, 15, 1'b0);
        #2 rst = 1'b1;
        #1;
        checks++; if (gmii.valid !== 1'b0 || gmii.data !== 8'h00 || gmii.error !== 1'b0) begin errors++; $display("FAIL mid_rst_gmii: got v=%b d=%h e=%b want 0/00/0", gmii.valid, gmii.data, gmii.error); end
        checks++; if (s_ready_o !== 1'b0 || error_pulse_o !== 1'b0) begin errors++; $display("FAIL mid_rst_ctl: got rdy=%b pulse=%b want 0/0", s_ready_o, error_pulse_o); end
        checks++; if (err_count() != 0 || pulse_cnt != 0) begin errors++; $display("FAIL mid_rst_noerr: got %0d/%0d want 0/0", err_count(), pulse_cnt); end
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_mon();
        for (int k = 0; k < 20; k++) txb[k] = 8'(8'hC0 + k * 3);
        tot = exp_total(20);
        send_frame(20, -1, 20, 1'b1);
        wait_quiet();
        checks++; if (mon_data.size() != 8 + tot + 4) begin errors++; $display("FAIL post_rst_len: got %0d want %0d", mon_data.size(), 8 + tot + 4); end
        checks++; if (hdr_bad(0) != 0 || data_bad(0, 20, tot) != 0) begin errors++; $display("FAIL post_rst_data: %0d/%0d bad bytes want 0/0", hdr_bad(0), data_bad(0, 20, tot)); end
        checks++; if (mon_fcs(8 + tot + 4) !== mon_crc(8, tot)) begin errors++; $display("FAIL post_rst_fcs: got %h want %h", mon_fcs(8 + tot + 4), mon_crc(8, tot)); end
        clear_mon();
    endtask

    initial begin
        test_reset();
        test_crc_vector();
        test_short_frame();
        test_underflow();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
